// File: rtl/regfile_decoded_mp.sv
// Multi-read-port register file with one-hot wordline decode on every port,
// a per-register busy scoreboard and an optional same-cycle write-to-read bypass.
module regfile_decoded_mp #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int ID_W     = 4,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ID_W-1:0]          wr_id,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [ID_W-1:0]          iss_id,
   input  logic [NUM_RD*ID_W-1:0]   rd_id,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [NUM_REGS-1:0]      busy_vec
);

   typedef logic [NUM_REGS-1:0] wl_t;

   // Register 0 is removed from every wordline when it is hard-wired to zero.
   localparam wl_t PROT_MASK = wl_t'((ZERO_REG != 0) ? 1 : 0);

   function automatic wl_t decode(input logic [ID_W-1:0] id);
      wl_t wl;
      wl     = '0;
      wl[id] = 1'b1;
      return wl;
   endfunction

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   wl_t               busy_q;
   wl_t               busy_d;
   wl_t               wr_wl;
   wl_t               iss_wl;

   always_comb begin
      wr_wl  = decode(wr_id)  & {NUM_REGS{wr_en}}  & ~PROT_MASK;
      iss_wl = decode(iss_id) & {NUM_REGS{iss_en}} & ~PROT_MASK;
   end

   always_comb begin
      // NOTE: every combinationally assigned signal gets a full default first,
      // so no path through the block can leave it holding and infer a latch.
      regs_d = regs_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_wl[i]) begin
            regs_d[i] = wr_data;
         end
      end
      // Issue is applied after the write clear so a new producer wins.
      busy_d = (busy_q & ~wr_wl) | iss_wl;
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of process evaluation order.
      if (rst) begin
         // NOTE: the whole array is reset because software relies on reading
         // zero from never-written registers; this forces a flop-based array.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   wl_t               rd_wl    [NUM_RD];
   logic [DATA_W-1:0] rd_word  [NUM_RD];
   logic [NUM_RD-1:0] byp_hit;
   logic [NUM_RD-1:0] rd_busy_raw;

   // Wired-OR read: AND each word with its wordline bit and OR everything.
   always_comb begin
      rd_data     = '0;
      rd_busy     = '0;
      byp_hit     = '0;
      rd_busy_raw = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_wl[k]   = decode(rd_id[k*ID_W +: ID_W]) & ~PROT_MASK;
         rd_word[k] = '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            rd_word[k] = rd_word[k] | (regs_q[i] & {DATA_W{rd_wl[k][i]}});
         end
         // wr_wl already carries wr_en and the register-0 mask.
         byp_hit[k]     = (BYPASS != 0) && (|(rd_wl[k] & wr_wl));
         rd_busy_raw[k] = |(rd_wl[k] & busy_q);
         rd_data[k*DATA_W +: DATA_W] = byp_hit[k] ? wr_data : rd_word[k];
         rd_busy[k]     = rd_busy_raw[k] & ~byp_hit[k];
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_decoded_mp.sv
// Bench for regfile_decoded_mp: instance A (16 regs, 2 ports, bypass) and
// instance B (32 regs, 3 ports, no bypass) checked against array models.
module tb_regfile_decoded_mp;

   logic clk;
   logic rst;

   logic        a_wr_en;
   logic [3:0]  a_wr_id;
   logic [15:0] a_wr_data;
   logic        a_iss_en;
   logic [3:0]  a_iss_id;
   logic [7:0]  a_rd_id;
   logic [31:0] a_rd_data;
   logic [1:0]  a_rd_busy;
   logic [15:0] a_busy_vec;

   logic        b_wr_en;
   logic [4:0]  b_wr_id;
   logic [15:0] b_wr_data;
   logic        b_iss_en;
   logic [4:0]  b_iss_id;
   logic [14:0] b_rd_id;
   logic [47:0] b_rd_data;
   logic [2:0]  b_rd_busy;
   logic [31:0] b_busy_vec;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   regfile_decoded_mp #(
      .DATA_W(16), .NUM_REGS(16), .ID_W(4), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)
   ) dut_a (
      .clk(clk), .rst(rst),
      .wr_en(a_wr_en), .wr_id(a_wr_id), .wr_data(a_wr_data),
      .iss_en(a_iss_en), .iss_id(a_iss_id),
      .rd_id(a_rd_id), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .busy_vec(a_busy_vec)
   );

   regfile_decoded_mp #(
      .DATA_W(16), .NUM_REGS(32), .ID_W(5), .NUM_RD(3), .BYPASS(0), .ZERO_REG(1)
   ) dut_b (
      .clk(clk), .rst(rst),
      .wr_en(b_wr_en), .wr_id(b_wr_id), .wr_data(b_wr_data),
      .iss_en(b_iss_en), .iss_id(b_iss_id),
      .rd_id(b_rd_id), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .busy_vec(b_busy_vec)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural model: plain arrays updated from the write/issue rules.
   logic [15:0] ma_reg [16];
   bit          ma_busy[16];
   logic [15:0] mb_reg [32];
   bit          mb_busy[32];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin ma_reg[i] = '0; ma_busy[i] = 0; end
         for (int i = 0; i < 32; i++) begin mb_reg[i] = '0; mb_busy[i] = 0; end
      end else begin
         if (a_wr_en && a_wr_id != 0) begin
            ma_reg[a_wr_id] = a_wr_data;
            ma_busy[a_wr_id] = 0;
         end
         if (a_iss_en && a_iss_id != 0) ma_busy[a_iss_id] = 1;
         if (b_wr_en && b_wr_id != 0) begin
            mb_reg[b_wr_id] = b_wr_data;
            mb_busy[b_wr_id] = 0;
         end
         if (b_iss_en && b_iss_id != 0) mb_busy[b_iss_id] = 1;
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] ev;
         for (int k = 0; k < 2; k++) begin
            automatic int r = int'(a_rd_id[k*4 +: 4]);
            automatic logic [15:0] ed;
            automatic logic        eb;
            if (r == 0) begin
               ed = '0; eb = 1'b0;
            end else if (a_wr_en && int'(a_wr_id) == r) begin
               ed = a_wr_data; eb = 1'b0;
            end else begin
               ed = ma_reg[r]; eb = ma_busy[r];
            end
            check($sformatf("a_rd_data[%0d]", k), 32'(a_rd_data[k*16 +: 16]), 32'(ed));
            check($sformatf("a_rd_busy[%0d]", k), 32'(a_rd_busy[k]), 32'(eb));
         end
         ev = '0;
         for (int i = 0; i < 16; i++) ev[i] = ma_busy[i];
         check("a_busy_vec", 32'(a_busy_vec), ev);
         for (int k = 0; k < 3; k++) begin
            automatic int r = int'(b_rd_id[k*5 +: 5]);
            automatic logic [15:0] ed = (r == 0) ? 16'h0 : mb_reg[r];
            automatic logic        eb = (r == 0) ? 1'b0 : mb_busy[r];
            check($sformatf("b_rd_data[%0d]", k), 32'(b_rd_data[k*16 +: 16]), 32'(ed));
            check($sformatf("b_rd_busy[%0d]", k), 32'(b_rd_busy[k]), 32'(eb));
         end
         ev = '0;
         for (int i = 0; i < 32; i++) ev[i] = mb_busy[i];
         check("b_busy_vec", b_busy_vec, ev);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      a_wr_en = 0; a_iss_en = 0; b_wr_en = 0; b_iss_en = 0;
   endtask

   initial begin
      rst = 1; idle_all();
      a_wr_id = '0; a_wr_data = '0; a_iss_id = '0; a_rd_id = '0;
      b_wr_id = '0; b_wr_data = '0; b_iss_id = '0; b_rd_id = '0;
      tick(); tick();
      rst = 0; chk_en = 1;
      a_rd_id = {4'd15, 4'd5};
      @(negedge clk);
      check("reset a_rd_data", a_rd_data, 32'h0);
      check("reset a_busy_vec", 32'(a_busy_vec), 32'h0);
      check("reset b_busy_vec", b_busy_vec, 32'h0);
      tick();

      // Fill every register, then read all indices back on both ports.
      for (int i = 0; i < 16; i++) begin
         a_wr_en = 1; a_wr_id = 4'(i); a_wr_data = 16'hA000 + 16'(i);
         tick();
      end
      a_wr_en = 0;
      for (int i = 0; i < 16; i++) begin
         a_rd_id = {4'(15 - i), 4'(i)};
         @(negedge clk);
         check("fill a port0", 32'(a_rd_data[15:0]), (i == 0) ? 32'h0 : 32'hA000 + 32'(i));
         check("fill a port1", 32'(a_rd_data[31:16]), (i == 15) ? 32'h0 : 32'hA00F - 32'(i));
         tick();
      end
      for (int i = 0; i < 32; i++) begin
         b_wr_en = 1; b_wr_id = 5'(i); b_wr_data = 16'hB000 + 16'(i);
         tick();
      end
      b_wr_en = 0;
      for (int i = 0; i < 32; i++) begin
         b_rd_id = {5'((i + 7) % 32), 5'(31 - i), 5'(i)};
         @(negedge clk);
         check("fill b port0", 32'(b_rd_data[15:0]), (i == 0) ? 32'h0 : 32'hB000 + 32'(i));
         check("fill b port1", 32'(b_rd_data[31:16]), (i == 31) ? 32'h0 : 32'hB01F - 32'(i));
         tick();
      end

      // Bypass on A, no bypass on B.
      a_wr_en = 1; a_wr_id = 3; a_wr_data = 16'h1234;
      b_wr_en = 1; b_wr_id = 3; b_wr_data = 16'h1234;
      tick();
      a_wr_data = 16'hBEEF; a_rd_id = {4'd1, 4'd3};
      b_wr_data = 16'hBEEF; b_rd_id = {5'd0, 5'd0, 5'd3};
      @(negedge clk);
      check("bypass a", 32'(a_rd_data[15:0]), 32'hBEEF);
      check("nobypass b old", 32'(b_rd_data[15:0]), 32'h1234);
      tick();
      idle_all();
      @(negedge clk);
      check("nobypass b new", 32'(b_rd_data[15:0]), 32'hBEEF);
      tick();

      // Issue marks busy; a later write clears it with bypassed busy=0.
      a_iss_en = 1; a_iss_id = 5; a_rd_id = {4'd1, 4'd5};
      tick();
      a_iss_en = 0;
      @(negedge clk);
      check("issue busy_vec", 32'(a_busy_vec), 32'h0020);
      check("issue rd_busy", 32'(a_rd_busy[0]), 32'h1);
      tick();
      a_wr_en = 1; a_wr_id = 5; a_wr_data = 16'h0555;
      @(negedge clk);
      check("write bypass busy", 32'(a_rd_busy[0]), 32'h0);
      tick();
      a_wr_en = 0;
      @(negedge clk);
      check("write clears busy", 32'(a_busy_vec), 32'h0);
      tick();

      // Issue and write to the same index: data written, busy set.
      a_iss_en = 1; a_iss_id = 7; a_wr_en = 1; a_wr_id = 7; a_wr_data = 16'h0042;
      a_rd_id = {4'd2, 4'd7};
      @(negedge clk);
      check("set-wins bypass busy", 32'(a_rd_busy[0]), 32'h0);
      tick();
      idle_all();
      @(negedge clk);
      check("set-wins data", 32'(a_rd_data[15:0]), 32'h0042);
      check("set-wins busy", 32'(a_busy_vec), 32'h0080);
      tick();

      // Register 0 stays zero and never busy.
      a_wr_en = 1; a_wr_id = 0; a_wr_data = 16'hFFFF; a_iss_en = 1; a_iss_id = 0;
      a_rd_id = {4'd0, 4'd0};
      @(negedge clk);
      check("zero reg bypass data", a_rd_data, 32'h0);
      check("zero reg bypass busy", 32'(a_rd_busy), 32'h0);
      tick();
      idle_all();
      @(negedge clk);
      check("zero reg data", a_rd_data, 32'h0);
      check("zero reg busy_vec0", 32'(a_busy_vec[0]), 32'h0);
      tick();

      // Reset in the middle of traffic wipes everything.
      a_wr_en = 1; a_wr_id = 2; a_wr_data = 16'h5555; a_iss_en = 1; a_iss_id = 2;
      tick();
      idle_all(); a_rd_id = {4'd4, 4'd2};
      @(negedge clk);
      check("pre-reset data", 32'(a_rd_data[15:0]), 32'h5555);
      check("pre-reset busy", 32'(a_busy_vec), 32'h0084);
      tick();
      rst = 1; a_wr_en = 1; a_wr_id = 4; a_wr_data = 16'h7777; a_iss_en = 1; a_iss_id = 6;
      b_wr_en = 1; b_wr_id = 9; b_wr_data = 16'h9999; b_iss_en = 1; b_iss_id = 9;
      tick();
      rst = 0; idle_all(); b_rd_id = {5'd9, 5'd31, 5'd3};
      @(negedge clk);
      check("post-reset a data", a_rd_data, 32'h0);
      check("post-reset a busy", 32'(a_busy_vec), 32'h0);
      check("post-reset b data", 32'(b_rd_data[47:32]), 32'h0);
      check("post-reset b busy", b_busy_vec, 32'h0);
      tick();

      // Randomised traffic on both instances against the model.
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         a_wr_en  = 1'($urandom); a_wr_id  = 4'($urandom); a_wr_data = 16'($urandom);
         a_iss_en = 1'($urandom); a_iss_id = ($urandom_range(0, 3) == 0) ? a_wr_id : 4'($urandom);
         b_wr_en  = 1'($urandom); b_wr_id  = 5'($urandom); b_wr_data = 16'($urandom);
         b_iss_en = 1'($urandom); b_iss_id = ($urandom_range(0, 3) == 0) ? b_wr_id : 5'($urandom);
         for (int k = 0; k < 2; k++)
            a_rd_id[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? a_wr_id : 4'($urandom);
         for (int k = 0; k < 3; k++)
            b_rd_id[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? b_wr_id : 5'($urandom);
         if ($urandom_range(0, 7) == 0) a_rd_id = {2{a_rd_id[3:0]}};
         if ($urandom_range(0, 7) == 0) b_rd_id = {3{b_rd_id[4:0]}};
         tick();
      end
      rst = 0; idle_all();
      tick();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_decoded_mp.md
Name: regfile_decoded_mp

Overview:
- Parametrised multi-read-port register file with one write port and internal one-hot wordline decoding for every port.
- Adds a per-register busy scoreboard for hazard detection and an optional write-to-read bypass.
- Sits in the CPU decode stage.
  - Read ports feed the ID/EX operands.
  - The write port is driven by writeback.
  - The issue port is driven by decode when an instruction with a destination register is dispatched.

Parameters:
- DATA_W, 16, bit width of each register.
- NUM_REGS, 16, number of registers; must be a power of two and at least 2.
- ID_W, 4, register index width; must equal log2(NUM_REGS).
- NUM_RD, 2, number of independent read ports (1..4).
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never marked busy.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write enable.
- wr_id  in  ID_W  write register index.
- wr_data  in  DATA_W  write data.
- iss_en  in  1  issue strobe: marks iss_id busy.
- iss_id  in  ID_W  index of the destination being issued.
- rd_id  in  NUM_RD*ID_W  packed read indices; port k occupies bits [k*ID_W +: ID_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  busy flag of the register each port is reading.
- busy_vec  out  NUM_REGS  full scoreboard; bit i is the busy flag of register i.

Behaviour:
- Clocking and reset
  - Single clock, one clk domain.
  - rst is synchronous and active-high; it takes effect only at a rising clk edge with rst=1.
  - Reset clears all registers to 0 and busy_vec to 0.
  - While rst=1, write and issue are ignored.
  - Outputs stay combinational on the register state, so immediately after the reset edge every rd_data is 0 and every rd_busy is 0.
- Decoding
  - Each port index is decoded to a NUM_REGS-bit one-hot wordline.
  - The write wordline is gated by wr_en; the issue wordline is gated by iss_en.
  - Read data is the OR of (wordline[i] AND reg[i]) over all i; no priority mux.
- Read timing
  - Latency 0 (combinational from rd_id and state).
  - Without bypass, a read returns the value committed at the previous edge.
- Write timing
  - With wr_en=1, reg[wr_id] takes wr_data at the rising edge.
  - The write also clears busy[wr_id] at the same edge.
- Bypass
  - Applies when BYPASS=1, wr_en=1, rd_id[k]==wr_id and the target is not the ZERO_REG-protected register 0.
  - Port k then returns wr_data in the same cycle, and rd_busy[k] reads 0 in that cycle.
  - With BYPASS=0, the old value and old busy flag are returned until the edge.
- Issue
  - iss_en=1 sets busy[iss_id] at the rising edge.
- Simultaneous events
  - iss_en and wr_en to the same index in one cycle: set wins, busy=1 after the edge (new producer). The data is still written.
  - The bypass in that cycle still returns wr_data, with rd_busy[k]=0 for that cycle.
  - Issue and write to different indices update independently.
  - All read ports may address the same register; each port returns the identical value.
- ZERO_REG=1
  - Writes to index 0 are dropped.
  - Issue to index 0 is dropped.
  - rd_data for index 0 is always 0 and rd_busy is always 0, including under bypass.
- Boundaries
  - Index NUM_REGS-1 must be decoded like any other index.
  - No out-of-range index exists, because ID_W = log2(NUM_REGS).
- Reset mid-operation
  - rst=1 with wr_en=1 and/or iss_en=1 in the same cycle: after the edge, state is all-zero and nothing is written or marked busy.
  - The combinational bypass still forwards wr_data during the reset cycle when BYPASS=1; this is permitted and must not be flagged by checkers.

Test Plan:
1. Reset, then for each i write reg[i]=16'hA000+i; next cycle read all indices on both ports → reg0=0 (ZERO_REG=1), reg i=16'hA000+i for i≥1, including reg15=16'hA00F.
2. With reg3=16'h1234, in one cycle drive wr_en=1, wr_id=3, wr_data=16'hBEEF, rd_id0=3 → rd_data0=16'hBEEF in that cycle (BYPASS=1). With BYPASS=0: 16'h1234 that cycle, 16'hBEEF the next.
3. iss_en=1, iss_id=5 → busy_vec=16'h0020 after the edge and rd_busy0=1 when reading 5. Then wr_en=1, wr_id=5 → rd_busy0=0 combinationally (bypass), and busy_vec=0 after the edge.
4. Same cycle iss_en=1, iss_id=7, wr_en=1, wr_id=7, wr_data=16'h0042 → after the edge reg7=16'h0042 and busy_vec[7]=1.
5. wr_en=1, wr_id=0, wr_data=16'hFFFF and iss_en=1, iss_id=0 → rd_data for index 0 is 0 (including the bypass cycle) and busy_vec[0]=0.
6. Load reg2=16'h5555 and busy[2]=1, then assert rst with wr_en=1, wr_id=4 → after the edge all reads are 0, busy_vec=0 and reg4=0. Repeat the full sequence at NUM_REGS=32, NUM_RD=3 with randomised ops against a scoreboard model.
